pwm_carrier_16bits: RTL
=======================

Name: pwm_carrier_16bits

Overview:
- Generates the 16-bit carrier and the shadowed compare value for the PWM comparator stage, which drives pwm high while carrier < compare.
- Supports sawtooth (up-count) and symmetric triangle (up/down) carriers, with a clock prescaler.
- Period, compare and mode are double-buffered and take effect only at the carrier zero point, so the downstream pwm never glitches mid-period.

Parameters:
- PRESCALE_W, 8, width of the prescale input and of the internal prescale counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk.
- enable  in  1  1 = carrier runs; 0 = carrier frozen and shadows transparent.
- mode  in  1  requested carrier shape: 0 = sawtooth, 1 = triangle.
- prescale  in  PRESCALE_W  carrier advances once every prescale+1 clk cycles.
- period  in  16  requested carrier peak value P.
- compare_in  in  16  requested compare value.
- carrier  out  16  carrier value, feeds the comparator carrier input.
- compare_out  out  16  shadowed compare value, feeds the comparator compare input.
- dir  out  1  1 = counting up, 0 = counting down; always 1 in sawtooth mode.
- zero_evt  out  1  one-clk pulse, registered together with the carrier update that sets carrier to 0.
- peak_evt  out  1  one-clk pulse, registered together with the carrier update that sets carrier to P.

Behaviour:
- Reset values: carrier=0, compare_out=0, dir=1, zero_evt=0, peak_evt=0. Internal state also resets: period_sh=0, mode_sh=0, pcnt=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Prescaler:
- pcnt runs only while enable=1.
- tick = enable & (pcnt >= prescale).
- On tick, pcnt clears to 0; otherwise pcnt increments by 1.
- The >= comparison means a prescale value reduced mid-count takes effect immediately, with no 2^W lockout.
- With prescale=0, tick occurs every clk.

Shadow load:
- period_sh, mode_sh and compare_out load from period, mode and compare_in:
  - every clk while enable=0;
  - on any tick that sets carrier to 0 while enable=1.
- A loaded value applies from the next tick.
- When a shadow load changes mode_sh to triangle, dir is set to 1.

Sawtooth (mode_sh=0), on tick:
- If carrier >= period_sh: carrier <= 0, zero_evt <= 1, shadows load.
- Else: carrier <= carrier+1; peak_evt <= 1 if carrier+1 == period_sh.
- The period is P+1 ticks.
- P = 0xFFFF counts to 0xFFFF and then wraps to 0 through the compare, not through arithmetic overflow.

Triangle (mode_sh=1), on tick:
- dir=1: carrier <= carrier+1; if carrier+1 == period_sh, then dir <= 0 and peak_evt <= 1.
- dir=0: carrier <= carrier-1; if carrier-1 == 0, then dir <= 1, zero_evt <= 1, shadows load.
- The period is 2P ticks.

Special cases:
- period_sh = 0, either mode: carrier stays 0, dir=1, zero_evt pulses on every tick, peak_evt never pulses.
- Event pulses are 0 on every cycle without a tick.
- enable falling mid-period: carrier and dir hold their values, pcnt clears to 0, events stay 0, shadows become transparent.
- enable rising: counting resumes from the held carrier using the shadows captured on the last enable=0 cycle.
- Triangle P = 1: carrier goes 0 → 1 (peak) → 0 (zero), alternating every tick.
- Async reset mid-operation: all state returns to reset values immediately; first tick after release occurs prescale+1 clks later.

Downstream semantics, informative:
- compare_out = 0 → pwm constantly 0.
- compare_out > P → pwm constantly 1.
- Duty cycle in sawtooth mode = C/(P+1).

Test Plan:
1. Sawtooth, prescale=0, P=4, C=2, enable after reset → carrier sequence 0,1,2,3,4,0,1,…; peak_evt on the cycle carrier=4; zero_evt on each wrap to 0; compare_out=2; comparator pwm high for 2 of every 5 clks.
2. Triangle, prescale=2, P=3 → carrier sequence 0,1,2,3,2,1,0,… with each value held 3 clks; dir falls with carrier=3 and rises with carrier=0; zero_evt and peak_evt each pulse once per 18 clks.
3. Mid-period shadow update: sawtooth P=9, change period to 5 and compare_in to 3 while carrier=6 → carrier continues to 9, wraps to 0, then peaks at 5; compare_out changes to 3 exactly on the wrap cycle.
4. Boundaries: P=0 → carrier stuck at 0 and zero_evt every tick. Sawtooth P=0xFFFF, prescale=0 → wrap from 0xFFFF to 0 after 65536 clks with zero_evt asserted.
5. enable dropped at carrier=7 for 10 clks, with mode changed to triangle during that time → carrier holds 7 and events stay 0; after re-enable the next tick gives 8, in triangle mode with dir=1.
6. rst_n asserted asynchronously mid-count (between clk edges) → carrier=0, compare_out=0, dir=1 immediately; after release, first increment occurs prescale+1 clks later.

Source files
------------

// File: rtl/pwm_carrier_16bits.sv
// pwm_carrier_16bits: prescaled sawtooth/triangle PWM carrier with shadowed period, compare and mode.
module pwm_carrier_16bits #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [15:0]           period,
  input  logic [15:0]           compare_in,
  output logic [15:0]           carrier,
  output logic [15:0]           compare_out,
  output logic                  dir,
  output logic                  zero_evt,
  output logic                  peak_evt
);
  logic [PRESCALE_W-1:0] pcnt;
  logic [15:0] period_sh, carrier_nx, inc, dec;
  logic mode_sh, tick, dir_nx, zero_nx, peak_nx, load;
  assign tick = enable && (pcnt >= prescale);
  assign inc = carrier + 16'd1;
  assign dec = carrier - 16'd1;
  // Every path into carrier 0 is a zero event and opens the shadow window.
  always_comb begin
    carrier_nx = carrier;
    dir_nx = dir;
    zero_nx = 1'b0;
    peak_nx = 1'b0;
    if (tick) begin
      if (period_sh == 16'd0 || (!mode_sh && carrier >= period_sh) || (mode_sh && !dir && carrier <= 16'd1)) begin
        carrier_nx = 16'd0;
        dir_nx = 1'b1;
        zero_nx = 1'b1;
      end else if (!mode_sh || dir) begin
        carrier_nx = inc;
        peak_nx = (inc == period_sh);
        dir_nx = !mode_sh || (inc < period_sh);
      end else begin
        carrier_nx = dec;
      end
    end
    load = !enable || zero_nx;
    if (load && (!mode || !mode_sh)) dir_nx = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      carrier <= 16'd0;
      dir <= 1'b1;
      zero_evt <= 1'b0;
      peak_evt <= 1'b0;
      period_sh <= 16'd0;
      mode_sh <= 1'b0;
      compare_out <= 16'd0;
    end else begin
      pcnt <= (!enable || tick) ? '0 : pcnt + 1'b1;
      carrier <= carrier_nx;
      dir <= dir_nx;
      zero_evt <= zero_nx;
      peak_evt <= peak_nx;
      if (load) begin
        period_sh <= period;
        mode_sh <= mode;
        compare_out <= compare_in;
      end
    end
  end
endmodule
